// File: rtl/fwd_hazard_unit_if.sv
// Decode-side bundle for the forwarding/hazard unit: ID fields and branch resolution in,
// EX operand selects plus stall/flush controls and event counters out.
interface fwd_hazard_unit_if #(
  parameter int INDEX     = 5,
  parameter int CNT_WIDTH = 16
);
  logic                 id_valid_in;
  logic [INDEX-1:0]     id_rs1_in;
  logic [INDEX-1:0]     id_rs2_in;
  logic [INDEX-1:0]     id_rd_in;
  logic                 id_reg_write_in;
  logic                 id_mem_read_in;
  logic                 ex_branch_taken_in;
  logic [1:0]           rs1_src_out;
  logic [1:0]           rs2_src_out;
  logic                 stall_out;
  logic                 flush_out;
  logic [CNT_WIDTH-1:0] stall_count_out;
  logic [CNT_WIDTH-1:0] flush_count_out;

  modport master (
    output id_valid_in, id_rs1_in, id_rs2_in, id_rd_in, id_reg_write_in, id_mem_read_in,
           ex_branch_taken_in,
    input  rs1_src_out, rs2_src_out, stall_out, flush_out, stall_count_out, flush_count_out
  );

  modport slave (
    input  id_valid_in, id_rs1_in, id_rs2_in, id_rd_in, id_reg_write_in, id_mem_read_in,
           ex_branch_taken_in,
    output rs1_src_out, rs2_src_out, stall_out, flush_out, stall_count_out, flush_count_out
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// EX operand forwarding selects (registered, 1-cycle latency) plus combinational load-use stall
// and branch flush; no backpressure of its own, stall/flush are the pipeline's backpressure.
module fwd_hazard_unit #(
  parameter int INDEX     = 5,
  parameter int CNT_WIDTH = 16
) (
  input  logic               clk_in,
  input  logic               rst_in,
  fwd_hazard_unit_if.slave   hz
);

  typedef struct packed {
    logic             valid;
    logic [INDEX-1:0] rd;
    logic             reg_write;
    logic             mem_read;
  } shadow_t;

  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_WB  = 2'b01;
  localparam logic [1:0] SEL_ALU = 2'b10;

  shadow_t ex_q, mem_q, wb_q, ex_d;
  state_t  state_q, state_d;
  logic [1:0] rs1_sel_d, rs2_sel_d, rs1_sel_q, rs2_sel_q;
  logic [CNT_WIDTH-1:0] stall_cnt_q, flush_cnt_q;
  logic load_use, stall, flush, accept, inc_stall, inc_flush;

  function automatic logic produces(input shadow_t s, input logic [INDEX-1:0] r);
    return s.valid && s.reg_write && (s.rd != '0) && (s.rd == r);
  endfunction

  // WB producers fall back to the register file: it is write-first.
  function automatic logic [1:0] pick_src(input logic [INDEX-1:0] r);
    if (produces(ex_q, r))       return SEL_ALU;
    else if (produces(mem_q, r)) return SEL_WB;
    else if (produces(wb_q, r))  return SEL_RF;
    else                         return SEL_RF;
  endfunction

  always_comb begin
    load_use  = hz.id_valid_in && ex_q.mem_read &&
                (produces(ex_q, hz.id_rs1_in) || produces(ex_q, hz.id_rs2_in));
    flush     = hz.ex_branch_taken_in;
    stall     = load_use && !flush;
    accept    = hz.id_valid_in && !stall && !flush;
    ex_d      = '0;
    rs1_sel_d = SEL_RF;
    rs2_sel_d = SEL_RF;
    if (accept) begin
      ex_d.valid     = 1'b1;
      ex_d.rd        = hz.id_rd_in;
      ex_d.reg_write = hz.id_reg_write_in;
      ex_d.mem_read  = hz.id_mem_read_in;
      rs1_sel_d      = pick_src(hz.id_rs1_in);
      rs2_sel_d      = pick_src(hz.id_rs2_in);
    end
  end

  always_comb begin
    state_d   = RUN;
    inc_stall = 1'b0;
    inc_flush = 1'b0;
    if (flush)         state_d = FLUSH;
    else if (load_use) state_d = STALL;
    case (state_q)
      STALL:   inc_stall = 1'b1;
      FLUSH:   inc_flush = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      rs1_sel_q <= SEL_RF;
      rs2_sel_q <= SEL_RF;
    end else begin
      ex_q      <= ex_d;
      mem_q     <= ex_q;
      wb_q      <= mem_q;
      rs1_sel_q <= rs1_sel_d;
      rs2_sel_q <= rs2_sel_d;
    end
  end

  // Counters hold at all-ones rather than wrapping.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (inc_stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (inc_flush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign hz.rs1_src_out     = rs1_sel_q;
  assign hz.rs2_src_out     = rs2_sel_q;
  assign hz.stall_out       = stall;
  assign hz.flush_out       = flush;
  assign hz.stall_count_out = stall_cnt_q;
  assign hz.flush_count_out = flush_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed scenarios plus a randomized run scored against an in-flight instruction queue model.
module tb_fwd_hazard_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit_if #(.INDEX(5), .CNT_WIDTH(16)) hif ();

  fwd_hazard_unit #(.INDEX(5), .CNT_WIDTH(16)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .hz     (hif.slave)
  );

  typedef struct {
    bit v;
    int rd;
    bit rw;
    bit mr;
  } ins_t;

  // Inputs change just after the falling edge; outputs are read 1 time unit later.
  task automatic issue(input bit v, input int rs1, input int rs2, input int rd,
                       input bit rw, input bit mr, input bit br);
    @(negedge clk);
    hif.id_valid_in        = v;
    hif.id_rs1_in          = rs1[4:0];
    hif.id_rs2_in          = rs2[4:0];
    hif.id_rd_in           = rd[4:0];
    hif.id_reg_write_in    = rw;
    hif.id_mem_read_in     = mr;
    hif.ex_branch_taken_in = br;
    #1;
  endtask

  task automatic nop();
    issue(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    checks++; if (hif.rs1_src_out !== 2'b00) begin errors++; $display("FAIL reset_rs1 got %b exp 00", hif.rs1_src_out); end
    checks++; if (hif.rs2_src_out !== 2'b00) begin errors++; $display("FAIL reset_rs2 got %b exp 00", hif.rs2_src_out); end
    checks++; if (hif.stall_out !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", hif.stall_out); end
    checks++; if (hif.flush_out !== 1'b0) begin errors++; $display("FAIL reset_flush got %b exp 0", hif.flush_out); end
    checks++; if (hif.stall_count_out !== 16'd0) begin errors++; $display("FAIL reset_stall_cnt got %0d exp 0", hif.stall_count_out); end
    checks++; if (hif.flush_count_out !== 16'd0) begin errors++; $display("FAIL reset_flush_cnt got %0d exp 0", hif.flush_count_out); end
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    nop();
  endtask

  task automatic test_fwd_alu();
    repeat (3) nop();
    issue(1, 1, 2, 3, 1, 0, 0);
    issue(1, 3, 3, 4, 1, 0, 0);
    checks++; if (hif.stall_out !== 1'b0) begin errors++; $display("FAIL alu_no_stall got %b exp 0", hif.stall_out); end
    nop();
    checks++; if (hif.rs1_src_out !== 2'b10) begin errors++; $display("FAIL alu_adj_rs1 got %b exp 10", hif.rs1_src_out); end
    checks++; if (hif.rs2_src_out !== 2'b10) begin errors++; $display("FAIL alu_adj_rs2 got %b exp 10", hif.rs2_src_out); end
    repeat (3) nop();
    issue(1, 1, 2, 3, 1, 0, 0);
    issue(1, 10, 11, 12, 1, 0, 0);
    issue(1, 3, 3, 4, 1, 0, 0);
    nop();
    checks++; if (hif.rs1_src_out !== 2'b01) begin errors++; $display("FAIL alu_gap_rs1 got %b exp 01", hif.rs1_src_out); end
    checks++; if (hif.rs2_src_out !== 2'b01) begin errors++; $display("FAIL alu_gap_rs2 got %b exp 01", hif.rs2_src_out); end
  endtask

  task automatic test_x0();
    repeat (3) nop();
    issue(1, 1, 2, 0, 1, 1, 0);
    issue(1, 0, 0, 6, 1, 0, 0);
    checks++; if (hif.stall_out !== 1'b0) begin errors++; $display("FAIL x0_stall got %b exp 0", hif.stall_out); end
    nop();
    checks++; if (hif.rs1_src_out !== 2'b00) begin errors++; $display("FAIL x0_rs1 got %b exp 00", hif.rs1_src_out); end
    checks++; if (hif.rs2_src_out !== 2'b00) begin errors++; $display("FAIL x0_rs2 got %b exp 00", hif.rs2_src_out); end
  endtask

  task automatic test_load_use();
    logic [15:0] sc0;
    repeat (3) nop();
    sc0 = hif.stall_count_out;
    issue(1, 1, 2, 7, 1, 1, 0);
    issue(1, 9, 7, 8, 1, 0, 0);
    checks++; if (hif.stall_out !== 1'b1) begin errors++; $display("FAIL lu_stall got %b exp 1", hif.stall_out); end
    checks++; if (hif.flush_out !== 1'b0) begin errors++; $display("FAIL lu_flush got %b exp 0", hif.flush_out); end
    issue(1, 9, 7, 8, 1, 0, 0);
    checks++; if (hif.stall_out !== 1'b0) begin errors++; $display("FAIL lu_one_cycle got %b exp 0", hif.stall_out); end
    checks++; if (hif.rs2_src_out !== 2'b00) begin errors++; $display("FAIL lu_bubble_rs2 got %b exp 00", hif.rs2_src_out); end
    nop();
    checks++; if (hif.rs2_src_out !== 2'b01) begin errors++; $display("FAIL lu_rs2 got %b exp 01", hif.rs2_src_out); end
    checks++; if (hif.rs1_src_out !== 2'b00) begin errors++; $display("FAIL lu_rs1 got %b exp 00", hif.rs1_src_out); end
    checks++; if (hif.stall_count_out !== sc0 + 16'd1) begin errors++; $display("FAIL lu_count got %0d exp %0d", hif.stall_count_out, sc0 + 16'd1); end
  endtask

  task automatic test_flush_priority();
    logic [15:0] sc0, fc0;
    repeat (3) nop();
    sc0 = hif.stall_count_out;
    fc0 = hif.flush_count_out;
    issue(1, 1, 2, 5, 1, 1, 0);
    issue(1, 5, 5, 6, 1, 0, 1);
    checks++; if (hif.flush_out !== 1'b1) begin errors++; $display("FAIL fp_flush got %b exp 1", hif.flush_out); end
    checks++; if (hif.stall_out !== 1'b0) begin errors++; $display("FAIL fp_stall got %b exp 0", hif.stall_out); end
    nop();
    checks++; if (hif.rs1_src_out !== 2'b00) begin errors++; $display("FAIL fp_bubble_rs1 got %b exp 00", hif.rs1_src_out); end
    nop();
    checks++; if (hif.flush_count_out !== fc0 + 16'd1) begin errors++; $display("FAIL fp_flush_cnt got %0d exp %0d", hif.flush_count_out, fc0 + 16'd1); end
    checks++; if (hif.stall_count_out !== sc0) begin errors++; $display("FAIL fp_stall_cnt got %0d exp %0d", hif.stall_count_out, sc0); end
  endtask

  task automatic test_reset_mid();
    repeat (3) nop();
    issue(1, 1, 2, 5, 1, 1, 0);
    issue(1, 5, 0, 6, 1, 0, 0);
    checks++; if (hif.stall_out !== 1'b1) begin errors++; $display("FAIL rm_pre_stall got %b exp 1", hif.stall_out); end
    rst = 1'b1;
    #1;
    checks++; if (hif.rs1_src_out !== 2'b00) begin errors++; $display("FAIL rm_rs1 got %b exp 00", hif.rs1_src_out); end
    checks++; if (hif.stall_out !== 1'b0) begin errors++; $display("FAIL rm_stall got %b exp 0", hif.stall_out); end
    checks++; if (hif.stall_count_out !== 16'd0) begin errors++; $display("FAIL rm_stall_cnt got %0d exp 0", hif.stall_count_out); end
    checks++; if (hif.flush_count_out !== 16'd0) begin errors++; $display("FAIL rm_flush_cnt got %0d exp 0", hif.flush_count_out); end
    @(negedge clk) rst = 1'b0;
    #1;
    checks++; if (hif.stall_out !== 1'b0) begin errors++; $display("FAIL rm_post_stall got %b exp 0", hif.stall_out); end
    nop();
    checks++; if (hif.rs1_src_out !== 2'b00) begin errors++; $display("FAIL rm_post_rs1 got %b exp 00", hif.rs1_src_out); end
  endtask

  task automatic test_random();
    ins_t pipe[$];
    ins_t bub, cur;
    int   exp_s1, exp_s2, st_total, st_last, fl_total, fl_last, e_st, e_fl;
    bit   v, rw, mr, br, lu, enter;
    int   rs1, rs2, rd;
    nop();
    rst = 1'b1;
    #1;
    @(negedge clk) rst = 1'b0;
    bub = '{v: 0, rd: 0, rw: 0, mr: 0};
    pipe = {bub, bub};
    exp_s1 = 0; exp_s2 = 0;
    st_total = 0; st_last = 0; fl_total = 0; fl_last = 0;
    for (int n = 0; n < 3000; n++) begin
      v   = ($urandom_range(0, 9) < 8);
      rs1 = $urandom_range(0, 3);
      rs2 = $urandom_range(0, 3);
      rd  = $urandom_range(0, 3);
      rw  = ($urandom_range(0, 9) < 7);
      mr  = ($urandom_range(0, 9) < 4);
      br  = ($urandom_range(0, 9) == 0);
      issue(v, rs1, rs2, rd, rw, mr, br);
      checks++; if (hif.rs1_src_out !== exp_s1[1:0]) begin errors++; $display("FAIL rnd_rs1 cyc %0d got %b exp %b", n, hif.rs1_src_out, exp_s1[1:0]); end
      checks++; if (hif.rs2_src_out !== exp_s2[1:0]) begin errors++; $display("FAIL rnd_rs2 cyc %0d got %b exp %b", n, hif.rs2_src_out, exp_s2[1:0]); end
      e_st = (st_total - st_last > 65535) ? 65535 : st_total - st_last;
      e_fl = (fl_total - fl_last > 65535) ? 65535 : fl_total - fl_last;
      checks++; if (hif.stall_count_out !== e_st[15:0]) begin errors++; $display("FAIL rnd_stall_cnt cyc %0d got %0d exp %0d", n, hif.stall_count_out, e_st); end
      checks++; if (hif.flush_count_out !== e_fl[15:0]) begin errors++; $display("FAIL rnd_flush_cnt cyc %0d got %0d exp %0d", n, hif.flush_count_out, e_fl); end
      // The instruction just ahead of ID is pipe[0]; a load there blocks a reader of its rd.
      lu = v && pipe[0].v && pipe[0].rw && pipe[0].mr && pipe[0].rd != 0 &&
           (pipe[0].rd == rs1 || pipe[0].rd == rs2);
      checks++; if (hif.stall_out !== (lu && !br)) begin errors++; $display("FAIL rnd_stall cyc %0d got %b exp %b", n, hif.stall_out, lu && !br); end
      checks++; if (hif.flush_out !== br) begin errors++; $display("FAIL rnd_flush cyc %0d got %b exp %b", n, hif.flush_out, br); end
      st_total += (lu && !br) ? 1 : 0; st_last = (lu && !br) ? 1 : 0;
      fl_total += br ? 1 : 0;          fl_last = br ? 1 : 0;
      enter = v && !lu && !br;
      exp_s1 = 0; exp_s2 = 0;
      if (enter) begin
        for (int k = 1; k >= 0; k--) begin
          if (pipe[k].v && pipe[k].rw && pipe[k].rd != 0 && pipe[k].rd == rs1) exp_s1 = 2 - k;
          if (pipe[k].v && pipe[k].rw && pipe[k].rd != 0 && pipe[k].rd == rs2) exp_s2 = 2 - k;
        end
      end
      cur = enter ? '{v: 1, rd: rd, rw: rw, mr: mr} : bub;
      pipe.push_front(cur);
      void'(pipe.pop_back());
    end
  endtask

  task automatic test_saturation();
    nop();
    rst = 1'b1;
    #1;
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 65541; i++) begin
      issue(0, 0, 0, 0, 0, 0, 1);
      if (i == 65000) begin
        checks++; if (hif.flush_count_out !== 16'd64999) begin errors++; $display("FAIL sat_mid got %0d exp 64999", hif.flush_count_out); end
      end
    end
    checks++; if (hif.flush_count_out !== 16'hFFFF) begin errors++; $display("FAIL sat_flush got %h exp ffff", hif.flush_count_out); end
    checks++; if (hif.stall_count_out !== 16'd0) begin errors++; $display("FAIL sat_stall got %0d exp 0", hif.stall_count_out); end
    nop();
    nop();
    checks++; if (hif.flush_count_out !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %h exp ffff", hif.flush_count_out); end
  endtask

  initial begin
    hif.id_valid_in        = 1'b0;
    hif.id_rs1_in          = '0;
    hif.id_rs2_in          = '0;
    hif.id_rd_in           = '0;
    hif.id_reg_write_in    = 1'b0;
    hif.id_mem_read_in     = 1'b0;
    hif.ex_branch_taken_in = 1'b0;
    test_reset();
    test_fwd_alu();
    test_x0();
    test_load_use();
    test_flush_priority();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Produces the per-operand forwarding selects that the EX stage consumes: the 2-bit RS1/RS2 source selects that choose register-file data, WB write data or EX/MEM ALU result.
- Also detects load-use and taken-branch hazards and drives pipeline stall and flush controls.
- Keeps its own shadow copy of the destination info for the EX, MEM and WB stages, so it sits beside the ID/EX register and needs only decode-stage and branch-resolution inputs.

Parameters:
- INDEX, 5, register index width.
- CNT_WIDTH, 16, width of the saturating hazard counters.

Ports:
- clk_in  in  1  core clock, rising edge.
- rst_in  in  1  reset, asynchronous, active-high.
- id_valid_in  in  1  a valid instruction is in the ID stage.
- id_rs1_in  in  INDEX  source register 1 of the ID instruction.
- id_rs2_in  in  INDEX  source register 2 of the ID instruction.
- id_rd_in  in  INDEX  destination register of the ID instruction.
- id_reg_write_in  in  1  the ID instruction writes rd.
- id_mem_read_in  in  1  the ID instruction is a load.
- ex_branch_taken_in  in  1  the EX instruction redirects the PC this cycle.
- rs1_src_out  out  2  EX select for rs1: 00 register file, 01 WB data, 10 EX/MEM ALU result, 11 unused.
- rs2_src_out  out  2  same encoding, for rs2.
- stall_out  out  1  hold the PC and IF/ID, insert a bubble into ID/EX.
- flush_out  out  1  kill the IF/ID and ID/EX contents.
- stall_count_out  out  CNT_WIDTH  saturating count of load-use stall cycles.
- flush_count_out  out  CNT_WIDTH  saturating count of flush cycles.

Behaviour:
- Shadow stages: three entries, EX, MEM and WB. Each holds {valid, rd, reg_write, mem_read}.
  - Every clock: WB <= MEM, MEM <= EX.
  - EX <= ID fields when id_valid_in=1 and neither stall nor flush is active; otherwise EX <= bubble (valid=0).
- Reset: all shadow entries invalid; rs1_src_out=rs2_src_out=00; stall_out=0; flush_out=0; both counters 0. Reset mid-operation discards all in-flight hazard state immediately.
- Producer qualification: a stage is a producer for operand r only when valid=1, reg_write=1, rd != 0 and rd == r. x0 is never forwarded.
- Select computation:
  - Done combinationally at decode from the current EX and MEM shadow entries, then registered into rs*_src_out. The selects are therefore valid during the cycle the instruction occupies EX (latency 1).
  - Priority: EX-shadow producer gives 10 (its result will be in EX/MEM next cycle). Else MEM-shadow producer gives 01 (its result will be WB data next cycle). Else 00.
  - The register file is write-first, so no WB-stage producer needs a select.
- When a bubble enters EX (stall, flush or id_valid_in=0), the registered selects are 00.
- stall_out and flush_out are combinational from the current inputs and shadow state.
- Load-use hazard: stall_out=1 when id_valid_in=1, the EX shadow is valid with mem_read=1 and reg_write=1, its rd != 0, and rd matches id_rs1_in or id_rs2_in.
  - Exactly one stall cycle results: next cycle the load is in MEM and the consumer gets select 01.
- Flush: flush_out = ex_branch_taken_in. Flush has priority over stall: when both are true, stall_out=0 and flush_out=1, and EX receives a bubble.
- FSM, states RUN, STALL, FLUSH:
  - Next state is registered each cycle: FLUSH if branch taken, else STALL if a load-use hazard, else RUN.
  - The FSM drives only the counters: +1 per cycle spent in STALL or FLUSH, holding at all-ones (no wrap).
  - Counters reflect events with one cycle of latency.
- Back-to-back loads with a dependent consumer: each load-use pair stalls once independently.
- Successive stall cycles cannot occur for the same consumer.

Test Plan:
- Reset asserted mid-stream while the EX shadow holds a load with rd=5 and a consumer reads x5 -> immediately rs1_src_out=00, stall_out=0, counters 0. After release, the same consumer produces no stall.
- ALU rd=3 followed directly by an instruction reading rs1=3, rs2=3 -> next cycle rs1_src_out=10, rs2_src_out=10. With one independent instruction between them -> both selects 01.
- Producer rd=0 with a consumer reading x0 -> selects 00, no stall.
- Load rd=7 followed by a consumer with rs2=7 -> stall_out=1 for exactly one cycle and an EX bubble with selects 00. Then the consumer enters EX with rs2_src_out=01, rs1_src_out=00, and stall_count_out=1.
- ex_branch_taken_in=1 in the same cycle as a load-use hazard -> flush_out=1, stall_out=0, EX bubble, flush_count_out increments by 1 and stall_count_out is unchanged.
- Hold a hazard condition for 2^16+5 cycles (CNT_WIDTH=16) -> the counter saturates at 0xFFFF and does not wrap.
